// File: rtl/led_chaser_multi.sv
`default_nettype none
// ============================================================================
//  Module   : led_chaser_multi
//  Brief    : N-LED chaser with four display modes (shift up, shift down,
//             bounce, fill bar). It has a debounced start/pause push-button
//             and a programmable step period.
//  Revision : 1.0 - initial release
// ============================================================================
module led_chaser_multi #(
  parameter int LED_NUM   = 8,
  parameter int CNT_MAX   = 100_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               button_i,
  input  logic [1:0]         mode_i,
  output logic [LED_NUM-1:0] led_o,
  output logic               running_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int CNT_W = (CNT_MAX   > 1) ? $clog2(CNT_MAX)   : 1;
  localparam int DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [DB_W-1:0]    DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0]    DB_ONE   = DB_W'(1);

  localparam logic [LED_NUM-1:0] LED_LSB  = {{(LED_NUM-1){1'b0}}, 1'b1};
  localparam logic [LED_NUM-1:0] LED_MSB  = {1'b1, {(LED_NUM-1){1'b0}}};
  localparam logic [LED_NUM-1:0] LED_ONES = {LED_NUM{1'b1}};

  localparam logic [1:0] MODE_UP     = 2'd0;
  localparam logic [1:0] MODE_DOWN   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic              btn_meta_q;
  logic              btn_sync_q;
  logic [DB_W-1:0]   db_cnt_q;
  logic [DB_W-1:0]   db_cnt_d;
  logic              db_level_q;
  logic              db_level_d;
  logic              db_level_prev_q;
  logic              btn_pulse;

  logic [1:0]        mode_meta_q;
  logic [1:0]        mode_sync_q;

  state_e            state_q;
  state_e            state_d;
  logic [LED_NUM-1:0] led_q;
  logic [LED_NUM-1:0] led_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              dir_q;
  logic              dir_d;
  logic [1:0]        mode_q;
  logic [1:0]        mode_d;
  logic              running_q;
  logic              running_d;

  logic [LED_NUM-1:0] step_led;
  logic              step_dir;
  logic              reload;

  // First lit pattern of a mode. Only shift-down starts at the top end.
  function automatic logic [LED_NUM-1:0] init_pattern(input logic [1:0] m);
    return (m == MODE_DOWN) ? LED_MSB : LED_LSB;
  endfunction

  // --------------------------------------------------------------------------
  // Button path: 2-FF synchroniser, debounce level, and rising-edge history
  // --------------------------------------------------------------------------
  // Register the button synchroniser and the debounce state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_meta_q      <= 1'b0;
      btn_sync_q      <= 1'b0;
      db_cnt_q        <= '0;
      db_level_q      <= 1'b0;
      db_level_prev_q <= 1'b0;
    end else begin
      btn_meta_q      <= button_i;
      btn_sync_q      <= btn_meta_q;
      db_cnt_q        <= db_cnt_d;
      db_level_q      <= db_level_d;
      db_level_prev_q <= db_level_q;
    end
  end

  // Accept a new level only after it has disagreed for DB_CYCLES cycles in a row
  always_comb begin
    db_cnt_d   = '0;
    db_level_d = db_level_q;
    if (btn_sync_q != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = btn_sync_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_ONE;
      end
    end
  end

  // Only a debounced press produces a pulse. A release produces nothing.
  assign btn_pulse = db_level_q & ~db_level_prev_q;

  // --------------------------------------------------------------------------
  // Mode path: 2-FF synchroniser
  // --------------------------------------------------------------------------
  // Register the mode-switch synchroniser
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_meta_q <= 2'd0;
      mode_sync_q <= 2'd0;
    end else begin
      mode_meta_q <= mode_i;
      mode_sync_q <= mode_meta_q;
    end
  end

  // --------------------------------------------------------------------------
  // Pattern step for the latched mode
  // --------------------------------------------------------------------------
  // Compute the next LED pattern and bounce direction for one step
  always_comb begin
    step_led = led_q;
    step_dir = dir_q;
    case (mode_q)
      MODE_UP: begin
        step_led = {led_q[LED_NUM-2:0], led_q[LED_NUM-1]};
      end
      MODE_DOWN: begin
        step_led = {led_q[0], led_q[LED_NUM-1:1]};
      end
      MODE_BOUNCE: begin
        // The direction flips on the step that reaches an end. Each end LED
        // therefore stays lit for exactly one step.
        if (dir_q == DIR_UP) begin
          step_led = led_q << 1;
          if (step_led[LED_NUM-1]) begin
            step_dir = DIR_DN;
          end
        end else begin
          step_led = led_q >> 1;
          if (step_led[0]) begin
            step_dir = DIR_UP;
          end
        end
      end
      default: begin
        // Fill bar: add one LED per step, then restart from a single LED
        if (led_q == LED_ONES) begin
          step_led = LED_LSB;
        end else begin
          step_led = {led_q[LED_NUM-2:0], 1'b1};
        end
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Main FSM
  // --------------------------------------------------------------------------
  // A mode change is only acted on once the chaser has been started
  assign reload = (state_q != ST_IDLE) && (mode_sync_q != mode_q);

  // Next-state logic. A mode reload overrides a step. A button pulse in RUN
  // pauses instead of stepping. If a pulse and a reload arrive together,
  // both take effect.
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    mode_d  = mode_q;

    case (state_q)
      ST_IDLE: begin
        led_d  = '0;
        mode_d = mode_sync_q;
        if (btn_pulse) begin
          state_d = ST_RUN;
          led_d   = init_pattern(mode_q);
          cnt_d   = '0;
          dir_d   = DIR_UP;
        end
      end
      ST_RUN: begin
        if (btn_pulse) begin
          state_d = ST_PAUSE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          led_d = step_led;
          dir_d = step_dir;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_PAUSE: begin
        if (btn_pulse) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        led_d   = '0;
        cnt_d   = '0;
        dir_d   = DIR_UP;
      end
    endcase

    if (reload) begin
      mode_d = mode_sync_q;
      led_d  = init_pattern(mode_sync_q);
      cnt_d  = '0;
      dir_d  = DIR_UP;
    end
  end

  assign running_d = (state_d == ST_RUN);

  // Register the FSM state, the pattern, the step counter and the running flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      led_q     <= '0;
      cnt_q     <= '0;
      dir_q     <= DIR_UP;
      mode_q    <= 2'd0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      led_q     <= led_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      mode_q    <= mode_d;
      running_q <= running_d;
    end
  end

  assign led_o     = led_q;
  assign running_o = running_q;

endmodule
`default_nettype wire

// File: tb/tb_led_chaser_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_chaser_multi
//  Brief    : Directed self-checking bench for led_chaser_multi
//             (LED_NUM=8, CNT_MAX=4, DB_CYCLES=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_chaser_multi;

  localparam int LED_NUM   = 8;
  localparam int CNT_MAX   = 4;
  localparam int DB_CYCLES = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       button = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] led;
  logic       running;

  int n_vec = 0;
  int n_err = 0;

  led_chaser_multi #(
    .LED_NUM   (LED_NUM),
    .CNT_MAX   (CNT_MAX),
    .DB_CYCLES (DB_CYCLES)
  ) u_dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .button_i  (button),
    .mode_i    (mode),
    .led_o     (led),
    .running_o (running)
  );

  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] m);
    rst_n  = 1'b0;
    button = 1'b0;
    mode   = m;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  // Press the button and hold it until running is seen (bounded), then
  // release it. While waiting, the LEDs must keep showing idle_led.
  task automatic start_run(input logic [7:0] idle_led, output int lat, output int bad);
    lat    = 0;
    bad    = 0;
    button = 1'b1;
    while (running !== 1'b1 && lat < 20) begin
      tick();
      lat++;
      if (running !== 1'b1 && led !== idle_led) bad++;
    end
    button = 1'b0;
  endtask

  initial begin
    int lat;
    int bad;
    int w;
    int pre;
    int post;
    int same;
    logic [7:0] exp;
    logic [7:0] last;
    logic [7:0] frozen;
    logic [7:0] glitch;

    // ---------------- Reset and start, shift up ----------------
    rst_n = 1'b0;
    repeat (3) tick();
    check_val("reset_led", 32'(led), 32'h00);
    check_val("reset_running", 32'(running), 32'h0);
    rst_n = 1'b1;
    repeat (3) tick();
    check_val("idle_led", 32'(led), 32'h00);
    start_run(8'h00, lat, bad);
    check_val("start_latency_in_window", 32'(lat >= DB_CYCLES + 2 && lat <= DB_CYCLES + 4), 32'h1);
    check_val("idle_led_before_pulse", 32'(bad), 32'h0);
    for (int k = 0; k < 36; k++) begin
      if (k > 0) tick();
      exp = 8'h01 << ((k / 4) % 8);
      check_val("shift_up", 32'({running, led}), 32'({1'b1, exp}));
    end

    // ---------------- Bounce ----------------
    do_reset(2'd2);
    start_run(8'h00, lat, bad);
    for (int k = 0; k < 64; k++) begin
      int s;
      int p;
      if (k > 0) tick();
      s = k / 4;
      p = (s <= 7) ? s : ((s <= 14) ? 14 - s : s - 14);
      exp = 8'h01 << p;
      check_val("bounce", 32'({running, led}), 32'({1'b1, exp}));
    end

    // ---------------- Fill bar ----------------
    do_reset(2'd3);
    start_run(8'h00, lat, bad);
    for (int k = 0; k < 36; k++) begin
      int n;
      if (k > 0) tick();
      n = (k / 4) % 8;
      exp = 8'((1 << (n + 1)) - 1);
      check_val("fill", 32'({running, led}), 32'({1'b1, exp}));
    end

    // ---------------- Mode change to shift down while running ----------------
    mode = 2'd1;
    w = 0;
    while (led !== 8'h80 && w < 6) begin
      tick();
      w++;
    end
    check_val("reload_within_3", 32'(w <= 3), 32'h1);
    for (int j = 1; j <= 8; j++) begin
      tick();
      exp = (j < 4) ? 8'h80 : ((j < 8) ? 8'h40 : 8'h20);
      check_val("shift_down_after_reload", 32'(led), 32'(exp));
    end

    // ---------------- Pause / glitch / resume ----------------
    do_reset(2'd0);
    start_run(8'h00, lat, bad);
    repeat (9) tick();
    button = 1'b1;
    same = 0;
    last = 8'h00;
    w = 0;
    while (running === 1'b1 && w < 20) begin
      if (led === last) same++;
      else begin
        same = 1;
        last = led;
      end
      tick();
      w++;
    end
    pre    = same;
    frozen = led;
    check_val("pause_running", 32'(running), 32'h0);
    check_val("pause_led", 32'(frozen), 32'h08);
    button = 1'b0;
    bad = 0;
    repeat (8) begin
      tick();
      if (led !== frozen || running !== 1'b0) bad++;
    end
    glitch = 8'b0011_0011;
    for (int i = 0; i < 8; i++) begin
      button = glitch[i];
      tick();
      if (led !== frozen || running !== 1'b0) bad++;
    end
    button = 1'b0;
    repeat (10) begin
      tick();
      if (led !== frozen || running !== 1'b0) bad++;
    end
    check_val("pause_hold_and_glitch_reject", 32'(bad), 32'h0);
    start_run(frozen, lat, bad);
    check_val("resume_running", 32'(running), 32'h1);
    check_val("paused_led_frozen", 32'(bad), 32'h0);
    post = 0;
    while (running === 1'b1 && led === frozen && post < 10) begin
      post++;
      tick();
    end
    check_val("resume_next_led", 32'(led), 32'h10);
    check_val("resume_step_timing", 32'(pre + post), 32'(CNT_MAX + 1));

    // ---------------- Async reset mid-step (led = 0x10) ----------------
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_reset_led", 32'(led), 32'h00);
    check_val("async_reset_running", 32'(running), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      tick();
      if (led !== 8'h00 || running !== 1'b0) bad++;
    end
    check_val("idle_after_reset", 32'(bad), 32'h0);
    start_run(8'h00, lat, bad);
    check_val("restart_after_reset", 32'({running, led}), 32'h101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
